// File: rtl/cursor_controller.sv
// ---------------------------------------------------------------------------
// cursor_controller
//
// Keeps the terminal cursor row/column registers in step with decoded VT52
// cursor commands. Moves clamp at the screen edges. LOAD_ROW/LOAD_COL give
// direct addressing. LF at the bottom row and RLF at the top row request a
// scroll from the video memory scroller over a level req / pulse ack handshake.
//
// Optional feature macro: CURSOR_AUTOWRAP_EN
//   defined   : ADVANCE at the last column wraps col to 0 and performs an LF
//               (row+1, or a scroll-up request on the bottom row).
//   undefined : ADVANCE at the last column holds the cursor (genuine VT52).
//
// Ports
//   clk        in   system clock, rising edge
//   clr_n      in   synchronous active-low reset
//   cmd_valid  in   command present on cmd/arg
//   cmd_ready  out  command accepted this cycle (IDLE state, unregistered decode)
//   cmd        in   4-bit command code (0..10 defined, 11..15 NOP)
//   arg        in   zero-based argument for LOAD_ROW / LOAD_COL
//   row        out  current cursor row    (registered)
//   col        out  current cursor column (registered)
//   scroll_req out  scroll request level, held until scroll_ack
//   scroll_dir out  0 = scroll up, 1 = scroll down
//   scroll_ack in   scroller finished; only honoured while a request is pending
// ---------------------------------------------------------------------------
module cursor_controller #(
  parameter int ROWS     = 24,
  parameter int COLS     = 80,
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 7
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd,
  input  logic [7:0]          arg,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                scroll_req,
  output logic                scroll_dir,
  input  logic                scroll_ack
);

  localparam logic [3:0] C_UP      = 4'd0;
  localparam logic [3:0] C_DOWN    = 4'd1;
  localparam logic [3:0] C_LEFT    = 4'd2;
  localparam logic [3:0] C_RIGHT   = 4'd3;
  localparam logic [3:0] C_HOME    = 4'd4;
  localparam logic [3:0] C_CR      = 4'd5;
  localparam logic [3:0] C_LF      = 4'd6;
  localparam logic [3:0] C_ADVANCE = 4'd7;
  localparam logic [3:0] C_LDROW   = 4'd8;
  localparam logic [3:0] C_LDCOL   = 4'd9;
  localparam logic [3:0] C_RLF     = 4'd10;

  // Increments are formed one bit wider than the field so the carry is
  // visible when compared against the last valid position.
  localparam logic [ROW_BITS:0] ROW_LAST = (ROW_BITS+1)'(ROWS-1);
  localparam logic [COL_BITS:0] COL_LAST = (COL_BITS+1)'(COLS-1);

  // Comparison width for LOAD_*: wide enough for both the 8-bit argument
  // and the limit, so a large arg never aliases into range.
  localparam int RAW = (ROW_BITS + 1 > 8) ? ROW_BITS + 1 : 8;
  localparam int CAW = (COL_BITS + 1 > 8) ? COL_BITS + 1 : 8;
  localparam logic [RAW-1:0] ROW_LIM = RAW'(ROWS-1);
  localparam logic [CAW-1:0] COL_LIM = CAW'(COLS-1);

  typedef enum logic {S_IDLE = 1'b0, S_SCROLL = 1'b1} state_t;

  state_t              r_state;
  logic [ROW_BITS-1:0] r_row;
  logic [COL_BITS-1:0] r_col;
  logic                r_scroll_req;
  logic                r_scroll_dir;

  logic [ROW_BITS:0]   w_row_inc;
  logic [COL_BITS:0]   w_col_inc;
  logic [RAW-1:0]      w_arg_row;
  logic [CAW-1:0]      w_arg_col;
  logic [ROW_BITS-1:0] w_row_nxt;
  logic [COL_BITS-1:0] w_col_nxt;
  logic                w_scroll;
  logic                w_dir;

  assign w_row_inc = {1'b0, r_row} + 1'b1;
  assign w_col_inc = {1'b0, r_col} + 1'b1;
  assign w_arg_row = RAW'(arg);
  assign w_arg_col = CAW'(arg);

  // Next cursor position and scroll decision for the command on cmd/arg.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_scroll  = 1'b0;
    w_dir     = 1'b0;
    case (cmd)
      C_UP:    if (r_row != '0) w_row_nxt = r_row - 1'b1;
      C_DOWN:  if (w_row_inc <= ROW_LAST) w_row_nxt = ROW_BITS'(w_row_inc);
      C_LEFT:  if (r_col != '0) w_col_nxt = r_col - 1'b1;
      C_RIGHT: if (w_col_inc <= COL_LAST) w_col_nxt = COL_BITS'(w_col_inc);
      C_HOME: begin
        w_row_nxt = '0;
        w_col_nxt = '0;
      end
      C_CR:    w_col_nxt = '0;
      C_LF: begin
        if (w_row_inc <= ROW_LAST) w_row_nxt = ROW_BITS'(w_row_inc);
        else                       w_scroll  = 1'b1;
      end
      C_ADVANCE: begin
        if (w_col_inc <= COL_LAST) begin
          w_col_nxt = COL_BITS'(w_col_inc);
        end else begin
`ifdef CURSOR_AUTOWRAP_EN
          // Wrap: column restarts immediately, the line feed either moves
          // down or asks the scroller to make room on the bottom row.
          w_col_nxt = '0;
          if (w_row_inc <= ROW_LAST) w_row_nxt = ROW_BITS'(w_row_inc);
          else                       w_scroll  = 1'b1;
`else
          w_col_nxt = r_col;
`endif
        end
      end
      C_LDROW: w_row_nxt = (w_arg_row > ROW_LIM) ? ROW_BITS'(ROWS-1) : ROW_BITS'(arg);
      C_LDCOL: w_col_nxt = (w_arg_col > COL_LIM) ? COL_BITS'(COLS-1) : COL_BITS'(arg);
      C_RLF: begin
        if (r_row != '0) begin
          w_row_nxt = r_row - 1'b1;
        end else begin
          w_scroll = 1'b1;
          w_dir    = 1'b1;
        end
      end
      default: ;  // codes 11..15: NOP
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_scroll_req <= 1'b0;
      r_scroll_dir <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // scroll_ack is deliberately ignored here.
          if (cmd_valid) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            if (w_scroll) begin
              r_state      <= S_SCROLL;
              r_scroll_req <= 1'b1;
              r_scroll_dir <= w_dir;
            end
          end
        end
        S_SCROLL: begin
          // Direction stays put for the whole request.
          if (scroll_ack) begin
            r_state      <= S_IDLE;
            r_scroll_req <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_scroll_req <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign row        = r_row;
  assign col        = r_col;
  assign scroll_req = r_scroll_req;
  assign scroll_dir = r_scroll_dir;

endmodule

// File: tb/tb_cursor_controller.sv
// ---------------------------------------------------------------------------
// tb_cursor_controller
//
// Directed bench for cursor_controller (ROWS=24, COLS=80). A table of
// single-command vectors covers clamping, addressing and NOPs in IDLE. The
// scroll handshake, the ADVANCE edge case and reset during a scroll are
// exercised as hand-written sequences.
// ---------------------------------------------------------------------------
module tb_cursor_controller;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd;
  logic [7:0] arg;
  logic [4:0] row;
  logic [6:0] col;
  logic       scroll_req;
  logic       scroll_dir;
  logic       scroll_ack;

  int n_vec = 0;
  int n_bad = 0;

  cursor_controller #(.ROWS(24), .COLS(80), .ROW_BITS(5), .COL_BITS(7)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .arg        (arg),
    .row        (row),
    .col        (col),
    .scroll_req (scroll_req),
    .scroll_dir (scroll_dir),
    .scroll_ack (scroll_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] arg;
    int         row;
    int         col;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one command for one edge, then sample 1 time unit later.
  task automatic issue(input logic [3:0] c, input logic [7:0] a);
    cmd_valid = 1'b1;
    cmd       = c;
    arg       = a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = 4'd15;
    arg       = 8'd0;
  endtask

  task automatic chk_idle(input string name, input int er, input int ec);
    chk({name, " row"}, int'(row), er);
    chk({name, " col"}, int'(col), ec);
    chk({name, " ready"}, int'(cmd_ready), 1);
    chk({name, " req"}, int'(scroll_req), 0);
  endtask

  initial begin
    tbl[0]  = '{4'd0,  8'd0,   0,  0};   // UP at top
    tbl[1]  = '{4'd2,  8'd0,   0,  0};   // LEFT at left
    tbl[2]  = '{4'd8,  8'd30,  23, 0};   // LOAD_ROW clamped
    tbl[3]  = '{4'd9,  8'd200, 23, 79};  // LOAD_COL clamped
    tbl[4]  = '{4'd3,  8'd0,   23, 79};  // RIGHT at right edge
    tbl[5]  = '{4'd1,  8'd0,   23, 79};  // DOWN at bottom, no scroll
    tbl[6]  = '{4'd0,  8'd0,   22, 79};
    tbl[7]  = '{4'd2,  8'd0,   22, 78};
    tbl[8]  = '{4'd5,  8'd0,   22, 0};   // CR
    tbl[9]  = '{4'd6,  8'd0,   23, 0};   // LF not at bottom
    tbl[10] = '{4'd12, 8'd0,   23, 0};   // NOP code
    tbl[11] = '{4'd4,  8'd0,   0,  0};   // HOME
    tbl[12] = '{4'd1,  8'd0,   1,  0};
    tbl[13] = '{4'd3,  8'd0,   1,  1};
    tbl[14] = '{4'd7,  8'd0,   1,  2};   // ADVANCE mid-line
    tbl[15] = '{4'd8,  8'd23,  23, 2};   // LOAD_ROW exactly last
    tbl[16] = '{4'd9,  8'd79,  23, 79};  // LOAD_COL exactly last
    tbl[17] = '{4'd8,  8'd5,   5,  79};

    clr_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 4'd15;
    arg        = 8'd0;
    scroll_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
    chk_idle("reset", 0, 0);
    chk("reset dir", int'(scroll_dir), 0);

    for (int i = 0; i < 18; i++) begin
      issue(tbl[i].cmd, tbl[i].arg);
      chk_idle($sformatf("vec%0d", i), tbl[i].row, tbl[i].col);
    end

    // LF at the bottom row, ack raised in the 5th request cycle; an UP is
    // held valid throughout and must wait for the first ready cycle.
    issue(4'd8, 8'd23);
    issue(4'd6, 8'd0);
    cmd_valid = 1'b1;
    cmd       = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("lf req c%0d", k), int'(scroll_req), 1);
      chk($sformatf("lf dir c%0d", k), int'(scroll_dir), 0);
      chk($sformatf("lf ready c%0d", k), int'(cmd_ready), 0);
      chk($sformatf("lf row c%0d", k), int'(row), 23);
      if (k == 5) scroll_ack = 1'b1;
      @(posedge clk);
      #1;
    end
    scroll_ack = 1'b0;
    chk("lf done req", int'(scroll_req), 0);
    chk("lf done ready", int'(cmd_ready), 1);
    chk("lf done row", int'(row), 23);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = 4'd15;
    chk("held UP row", int'(row), 22);
    chk("held UP req", int'(scroll_req), 0);

    // RLF at the top row, ack in the first request cycle.
    issue(4'd4, 8'd0);
    issue(4'd10, 8'd0);
    chk("rlf req", int'(scroll_req), 1);
    chk("rlf dir", int'(scroll_dir), 1);
    chk("rlf ready", int'(cmd_ready), 0);
    chk("rlf row", int'(row), 0);
    scroll_ack = 1'b1;
    @(posedge clk);
    #1;
    scroll_ack = 1'b0;
    chk_idle("rlf done", 0, 0);

    // ADVANCE at the bottom-right corner.
    issue(4'd8, 8'd23);
    issue(4'd9, 8'd79);
    issue(4'd7, 8'd0);
`ifdef CURSOR_AUTOWRAP_EN
    chk("adv row", int'(row), 23);
    chk("adv col", int'(col), 0);
    chk("adv req", int'(scroll_req), 1);
    chk("adv dir", int'(scroll_dir), 0);
    scroll_ack = 1'b1;
    @(posedge clk);
    #1;
    scroll_ack = 1'b0;
    chk_idle("adv done", 23, 0);
`else
    chk_idle("adv hold", 23, 79);
`endif

    // Reset while a scroll is pending, then a stray ack.
    issue(4'd9, 8'd10);
    issue(4'd6, 8'd0);
    chk("pre-rst req", int'(scroll_req), 1);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    chk_idle("rst abort", 0, 0);
    scroll_ack = 1'b1;
    @(posedge clk);
    #1;
    scroll_ack = 1'b0;
    chk_idle("stray ack", 0, 0);
    chk("stray ack dir", int'(scroll_dir), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
